// File: rtl/load_store_buffer_pkg.sv
// rtl/load_store_buffer_pkg.sv - shared CPU constants for the load/store buffer
package load_store_buffer_pkg;

  localparam int LSB_SIZE  = 8;
  localparam int ROB_TAG_W = 4;
  localparam logic [ROB_TAG_W-1:0] TAG_NONE = '0;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_LBU = 3'd3,
    OP_LHU = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } lsb_op_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DISCARD  = 2'd2
  } lsb_state_e;

  function automatic mem_size_e op_size(input logic [2:0] op);
    case (lsb_op_e'(op))
      OP_LB, OP_LBU, OP_SB: return SIZE_BYTE;
      OP_LH, OP_LHU, OP_SH: return SIZE_HALF;
      default:              return SIZE_WORD;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - sign/zero extension of load data by op
module load_extend
  import load_store_buffer_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rdata,
  output logic [31:0] value
);

  always_comb begin
    value = rdata;
    case (lsb_op_e'(op))
      OP_LB:   value = {{24{rdata[7]}}, rdata[7:0]};
      OP_LH:   value = {{16{rdata[15]}}, rdata[15:0]};
      OP_LBU:  value = {24'd0, rdata[7:0]};
      OP_LHU:  value = {16'd0, rdata[15:0]};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_buffer.sv
// rtl/load_store_buffer.sv - in-order load/store queue with single in-flight memory op
module load_store_buffer #(
  parameter int LSB_SIZE  = load_store_buffer_pkg::LSB_SIZE,
  parameter int ROB_TAG_W = load_store_buffer_pkg::ROB_TAG_W
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  output logic                 lsb_full,
  input  logic                 decoder2lsb_enable,
  input  logic [2:0]           decoder2lsb_op,
  input  logic [31:0]          decoder2lsb_vj,
  input  logic [31:0]          decoder2lsb_vk,
  input  logic [ROB_TAG_W-1:0] decoder2lsb_qj,
  input  logic [ROB_TAG_W-1:0] decoder2lsb_qk,
  input  logic [31:0]          decoder2lsb_imm,
  input  logic [ROB_TAG_W-1:0] decoder2lsb_dest,
  input  logic                 alu2lsb_bypass_enable,
  input  logic [ROB_TAG_W-1:0] alu2lsb_bypass_reorder,
  input  logic [31:0]          alu2lsb_bypass_value,
  output logic                 lsu2rs_bypass_enable,
  output logic [ROB_TAG_W-1:0] lsu2rs_bypass_reorder,
  output logic [31:0]          lsu2rs_bypass_value,
  input  logic                 rob2lsb_commit_enable,
  input  logic [ROB_TAG_W-1:0] rob2lsb_commit_reorder,
  input  logic                 rob2lsb_flush,
  output logic                 lsb2mem_enable,
  output logic                 lsb2mem_wr,
  output logic [31:0]          lsb2mem_addr,
  output logic [31:0]          lsb2mem_wdata,
  output logic [1:0]           lsb2mem_size,
  input  logic                 mem2lsb_done,
  input  logic [31:0]          mem2lsb_rdata
);
  import load_store_buffer_pkg::*;

  localparam int IDX_W = (LSB_SIZE > 1) ? $clog2(LSB_SIZE) : 1;
  localparam int CNT_W = $clog2(LSB_SIZE + 1);
  localparam logic [ROB_TAG_W-1:0] TAG_Z = ROB_TAG_W'(TAG_NONE);

  logic [IDX_W-1:0]     head, tail;
  logic [CNT_W-1:0]     count, ncommit;
  logic                 e_valid     [LSB_SIZE];
  logic                 e_committed [LSB_SIZE];
  logic                 e_announced [LSB_SIZE];
  logic                 commit_hit  [LSB_SIZE];
  logic [2:0]           e_op        [LSB_SIZE];
  logic [31:0]          e_vj        [LSB_SIZE];
  logic [31:0]          e_vk        [LSB_SIZE];
  logic [31:0]          e_imm       [LSB_SIZE];
  logic [ROB_TAG_W-1:0] e_qj        [LSB_SIZE];
  logic [ROB_TAG_W-1:0] e_qk        [LSB_SIZE];
  logic [ROB_TAG_W-1:0] e_dest      [LSB_SIZE];

  lsb_state_e state, state_nx;
  logic issue_ld, issue_st, done_ld, done_st, mem_ack, announce, enq, deq, in_prefix;
  logic h_store, h_ld_ready, h_st_ready;
  logic [31:0] ext_value;

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] base, input int n);
    int s;
    s = int'(base) + n;
    if (s >= LSB_SIZE) s = s - LSB_SIZE;
    return IDX_W'(s);
  endfunction

  // Returns {q, v} after applying whichever broadcast resolves the tag this cycle.
  function automatic logic [ROB_TAG_W+31:0] snoop(input logic [ROB_TAG_W-1:0] q,
                                                  input logic [31:0] v);
    if (q != TAG_Z && alu2lsb_bypass_enable && alu2lsb_bypass_reorder == q)
      return {TAG_Z, alu2lsb_bypass_value};
    if (q != TAG_Z && lsu2rs_bypass_enable && lsu2rs_bypass_reorder == q)
      return {TAG_Z, lsu2rs_bypass_value};
    return {q, v};
  endfunction

  load_extend u_load_extend (
    .op    (e_op[head]),
    .rdata (mem2lsb_rdata),
    .value (ext_value)
  );

  assign lsb_full   = (int'(count) == LSB_SIZE);
  assign h_store    = op_is_store(e_op[head]);
  assign h_ld_ready = e_valid[head] && !h_store && e_qj[head] == TAG_Z;
  assign h_st_ready = e_valid[head] && h_store && e_qj[head] == TAG_Z && e_qk[head] == TAG_Z;
  assign enq        = decoder2lsb_enable && (int'(count) < LSB_SIZE) && !rob2lsb_flush;
  assign deq        = done_ld || done_st;
  assign announce   = h_st_ready && !e_announced[head] && !done_ld && !rob2lsb_flush;

  // Committed stores always sit at the front of the queue; count that prefix for flush.
  always_comb begin
    ncommit   = '0;
    in_prefix = 1'b1;
    for (int i = 0; i < LSB_SIZE; i++) begin
      commit_hit[i] = e_valid[i] && op_is_store(e_op[i]) &&
                      (e_committed[i] ||
                       (rob2lsb_commit_enable && rob2lsb_commit_reorder == e_dest[i]));
    end
    for (int i = 0; i < LSB_SIZE; i++) begin
      if (in_prefix && i < int'(count) && commit_hit[idx_inc(head, i)])
        ncommit = ncommit + CNT_W'(1);
      else
        in_prefix = 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    issue_ld = 1'b0;
    issue_st = 1'b0;
    done_ld  = 1'b0;
    done_st  = 1'b0;
    mem_ack  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rob2lsb_flush) begin
          if (h_ld_ready)
            issue_ld = 1'b1;
          else if (h_st_ready && e_committed[head] && e_announced[head])
            issue_st = 1'b1;
        end
        if (issue_ld || issue_st) state_nx = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        if (mem2lsb_done) begin
          mem_ack  = 1'b1;
          state_nx = ST_IDLE;
          if (lsb2mem_wr)          done_st = 1'b1;
          else if (!rob2lsb_flush) done_ld = 1'b1;
        end else if (rob2lsb_flush && !lsb2mem_wr) begin
          state_nx = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (mem2lsb_done) begin
          mem_ack  = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in)      state <= ST_IDLE;
    else if (rdy_in) state <= state_nx;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < LSB_SIZE; i++) begin
        e_valid[i]     <= 1'b0;
        e_committed[i] <= 1'b0;
        e_announced[i] <= 1'b0;
      end
      lsb2mem_enable        <= 1'b0;
      lsb2mem_wr            <= 1'b0;
      lsb2mem_addr          <= '0;
      lsb2mem_wdata         <= '0;
      lsb2mem_size          <= '0;
      lsu2rs_bypass_enable  <= 1'b0;
      lsu2rs_bypass_reorder <= '0;
      lsu2rs_bypass_value   <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < LSB_SIZE; i++) begin
        if (e_valid[i]) begin
          if (commit_hit[i]) e_committed[i] <= 1'b1;
          {e_qj[i], e_vj[i]} <= snoop(e_qj[i], e_vj[i]);
          {e_qk[i], e_vk[i]} <= snoop(e_qk[i], e_vk[i]);
          if (rob2lsb_flush && !commit_hit[i]) e_valid[i] <= 1'b0;
        end
      end
      if (announce) e_announced[head] <= 1'b1;
      if (deq) begin
        e_valid[head] <= 1'b0;
        head          <= idx_inc(head, 1);
      end
      if (enq) begin
        e_valid[tail]          <= 1'b1;
        e_committed[tail]      <= 1'b0;
        e_announced[tail]      <= 1'b0;
        e_op[tail]             <= decoder2lsb_op;
        e_imm[tail]            <= decoder2lsb_imm;
        e_dest[tail]           <= decoder2lsb_dest;
        {e_qj[tail], e_vj[tail]} <= snoop(decoder2lsb_qj, decoder2lsb_vj);
        {e_qk[tail], e_vk[tail]} <= snoop(decoder2lsb_qk, decoder2lsb_vk);
      end
      if (rob2lsb_flush) begin
        count <= ncommit - CNT_W'(done_st);
        tail  <= idx_inc(head, int'(ncommit));
      end else begin
        count <= count + CNT_W'(enq) - CNT_W'(deq);
        if (enq) tail <= idx_inc(tail, 1);
      end

      if (issue_ld || issue_st) begin
        lsb2mem_enable <= 1'b1;
        lsb2mem_wr     <= issue_st;
        lsb2mem_addr   <= e_vj[head] + e_imm[head];
        lsb2mem_wdata  <= issue_st ? e_vk[head] : 32'd0;
        lsb2mem_size   <= op_size(e_op[head]);
      end else if (mem_ack) begin
        lsb2mem_enable <= 1'b0;
      end

      lsu2rs_bypass_enable  <= 1'b0;
      lsu2rs_bypass_reorder <= '0;
      lsu2rs_bypass_value   <= '0;
      if (done_ld) begin
        lsu2rs_bypass_enable  <= 1'b1;
        lsu2rs_bypass_reorder <= e_dest[head];
        lsu2rs_bypass_value   <= ext_value;
      end else if (announce) begin
        lsu2rs_bypass_enable  <= 1'b1;
        lsu2rs_bypass_reorder <= e_dest[head];
      end
    end
  end

endmodule

// File: tb/tb_load_store_buffer.sv
// tb/tb_load_store_buffer.sv - scoreboard bench for load_store_buffer
module tb_load_store_buffer;
  import load_store_buffer_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, lsb_full;
  logic        decoder2lsb_enable;
  logic [2:0]  decoder2lsb_op;
  logic [31:0] decoder2lsb_vj, decoder2lsb_vk, decoder2lsb_imm;
  logic [3:0]  decoder2lsb_qj, decoder2lsb_qk, decoder2lsb_dest;
  logic        alu2lsb_bypass_enable;
  logic [3:0]  alu2lsb_bypass_reorder;
  logic [31:0] alu2lsb_bypass_value;
  logic        lsu2rs_bypass_enable;
  logic [3:0]  lsu2rs_bypass_reorder;
  logic [31:0] lsu2rs_bypass_value;
  logic        rob2lsb_commit_enable, rob2lsb_flush;
  logic [3:0]  rob2lsb_commit_reorder;
  logic        lsb2mem_enable, lsb2mem_wr, mem2lsb_done;
  logic [31:0] lsb2mem_addr, lsb2mem_wdata, mem2lsb_rdata;
  logic [1:0]  lsb2mem_size;

  always #5 clk_in = ~clk_in;

  load_store_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .lsb_full(lsb_full),
    .decoder2lsb_enable(decoder2lsb_enable), .decoder2lsb_op(decoder2lsb_op),
    .decoder2lsb_vj(decoder2lsb_vj), .decoder2lsb_vk(decoder2lsb_vk),
    .decoder2lsb_qj(decoder2lsb_qj), .decoder2lsb_qk(decoder2lsb_qk),
    .decoder2lsb_imm(decoder2lsb_imm), .decoder2lsb_dest(decoder2lsb_dest),
    .alu2lsb_bypass_enable(alu2lsb_bypass_enable), .alu2lsb_bypass_reorder(alu2lsb_bypass_reorder),
    .alu2lsb_bypass_value(alu2lsb_bypass_value),
    .lsu2rs_bypass_enable(lsu2rs_bypass_enable), .lsu2rs_bypass_reorder(lsu2rs_bypass_reorder),
    .lsu2rs_bypass_value(lsu2rs_bypass_value),
    .rob2lsb_commit_enable(rob2lsb_commit_enable), .rob2lsb_commit_reorder(rob2lsb_commit_reorder),
    .rob2lsb_flush(rob2lsb_flush),
    .lsb2mem_enable(lsb2mem_enable), .lsb2mem_wr(lsb2mem_wr), .lsb2mem_addr(lsb2mem_addr),
    .lsb2mem_wdata(lsb2mem_wdata), .lsb2mem_size(lsb2mem_size),
    .mem2lsb_done(mem2lsb_done), .mem2lsb_rdata(mem2lsb_rdata)
  );

  typedef struct { logic [3:0] tag; logic [31:0] value; } bcast_t;
  typedef struct { logic wr; logic [31:0] addr; logic [31:0] wdata; logic [1:0] size; } memreq_t;

  bcast_t  exp_bcast[$];
  memreq_t exp_req[$];
  int      n_checks = 0;
  int      n_fail   = 0;
  bit      monitor_on = 1'b0;

  initial begin : bcast_monitor
    bcast_t e;
    forever begin
      @(negedge clk_in);
      if (monitor_on && lsu2rs_bypass_enable) begin
        n_checks++;
        if (exp_bcast.size() == 0) begin
          n_fail++;
          $display("FAIL bcast_unexpected: got tag %0d value %h, none required",
                   lsu2rs_bypass_reorder, lsu2rs_bypass_value);
        end else begin
          e = exp_bcast.pop_front();
          if (lsu2rs_bypass_reorder !== e.tag || lsu2rs_bypass_value !== e.value) begin
            n_fail++;
            $display("FAIL bcast_value: got tag %0d value %h, required tag %0d value %h",
                     lsu2rs_bypass_reorder, lsu2rs_bypass_value, e.tag, e.value);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic dispatch(input logic [2:0] op, input logic [31:0] vj, input logic [31:0] vk,
                          input logic [3:0] qj, input logic [3:0] qk, input logic [31:0] imm,
                          input logic [3:0] dest);
    decoder2lsb_enable = 1'b1;
    decoder2lsb_op = op; decoder2lsb_vj = vj; decoder2lsb_vk = vk;
    decoder2lsb_qj = qj; decoder2lsb_qk = qk; decoder2lsb_imm = imm; decoder2lsb_dest = dest;
    @(negedge clk_in);
    decoder2lsb_enable = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    int i;
    ok = 1'b0;
    i = 0;
    while (!ok && i < 40) begin
      if (lsb2mem_enable) ok = 1'b1;
      else begin @(negedge clk_in); i++; end
    end
  endtask

  task automatic pulse_done(input logic [31:0] data);
    mem2lsb_rdata = data;
    mem2lsb_done  = 1'b1;
    @(negedge clk_in);
    mem2lsb_done  = 1'b0;
  endtask

  task automatic one_cycle_flush();
    rob2lsb_flush = 1'b1;
    @(negedge clk_in);
    rob2lsb_flush = 1'b0;
  endtask

  task automatic commit(input logic [3:0] tag);
    rob2lsb_commit_enable = 1'b1; rob2lsb_commit_reorder = tag;
    @(negedge clk_in);
    rob2lsb_commit_enable = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1;
    decoder2lsb_enable = 0; decoder2lsb_op = 0; decoder2lsb_vj = 0; decoder2lsb_vk = 0;
    decoder2lsb_qj = 0; decoder2lsb_qk = 0; decoder2lsb_imm = 0; decoder2lsb_dest = 0;
    alu2lsb_bypass_enable = 0; alu2lsb_bypass_reorder = 0; alu2lsb_bypass_value = 0;
    rob2lsb_commit_enable = 0; rob2lsb_commit_reorder = 0; rob2lsb_flush = 0;
    mem2lsb_done = 0; mem2lsb_rdata = 0;
    cycles(3);
    n_checks++;
    if ({lsb_full, lsb2mem_enable, lsb2mem_wr, lsu2rs_bypass_enable} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b, required 0000",
                         {lsb_full, lsb2mem_enable, lsb2mem_wr, lsu2rs_bypass_enable});
    end
    n_checks++;
    if (lsb2mem_addr !== 32'd0 || lsu2rs_bypass_value !== 32'd0) begin
      n_fail++; $display("FAIL reset_data: got addr %h value %h, required 0 0",
                         lsb2mem_addr, lsu2rs_bypass_value);
    end
    n_checks++;
    if (dut.count !== 4'd0 || dut.state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_state: got count %0d state %0d, required 0 0",
                         dut.count, dut.state);
    end
    rst_in = 1'b0;
    monitor_on = 1'b1;
    cycles(1);
  endtask

  task automatic test_load();
    bit ok;
    memreq_t e;
    exp_req.push_back('{1'b0, 32'h104, 32'h0, 2'd0});
    exp_bcast.push_back('{4'd3, 32'hFFFF_FF80});
    dispatch(OP_LB, 32'h100, 32'h0, 4'd0, 4'd0, 32'd4, 4'd3);
    wait_req(ok);
    e = exp_req.pop_front();
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL load_req: got no request, required addr %h", e.addr); end
    else if ({lsb2mem_wr, lsb2mem_addr, lsb2mem_size} !== {e.wr, e.addr, e.size}) begin
      n_fail++; $display("FAIL load_req: got wr %b addr %h size %0d, required wr %b addr %h size %0d",
                         lsb2mem_wr, lsb2mem_addr, lsb2mem_size, e.wr, e.addr, e.size);
    end
    repeat (2) begin
      @(negedge clk_in);
      n_checks++;
      if (lsb2mem_enable !== 1'b1 || lsb2mem_addr !== 32'h104) begin
        n_fail++; $display("FAIL load_hold: got en %b addr %h, required 1 00000104",
                           lsb2mem_enable, lsb2mem_addr);
      end
    end
    pulse_done(32'h0000_0080);
    n_checks++;
    if (lsb2mem_enable !== 1'b0) begin
      n_fail++; $display("FAIL load_drop_enable: got %b, required 0", lsb2mem_enable);
    end
    cycles(3);
    n_checks++;
    if (exp_bcast.size() != 0 || dut.count !== 4'd0) begin
      n_fail++; $display("FAIL load_complete: got pending bcast %0d count %0d, required 0 0",
                         exp_bcast.size(), dut.count);
    end
  endtask

  task automatic test_store_commit();
    bit ok;
    memreq_t e;
    exp_bcast.push_back('{4'd6, 32'h0});
    exp_req.push_back('{1'b1, 32'h208, 32'hDEAD_BEEF, 2'd2});
    dispatch(OP_SW, 32'h200, 32'h0, 4'd0, 4'd5, 32'd8, 4'd6);
    cycles(3);
    n_checks++;
    if (exp_bcast.size() != 1 || lsb2mem_enable !== 1'b0) begin
      n_fail++; $display("FAIL store_early: got pending bcast %0d en %b, required 1 0",
                         exp_bcast.size(), lsb2mem_enable);
    end
    alu2lsb_bypass_enable = 1'b1; alu2lsb_bypass_reorder = 4'd5; alu2lsb_bypass_value = 32'hDEAD_BEEF;
    @(negedge clk_in);
    alu2lsb_bypass_enable = 1'b0;
    cycles(3);
    n_checks++;
    if (exp_bcast.size() != 0 || lsb2mem_enable !== 1'b0) begin
      n_fail++; $display("FAIL store_announce: got pending bcast %0d en %b, required 0 0",
                         exp_bcast.size(), lsb2mem_enable);
    end
    commit(4'd6);
    wait_req(ok);
    e = exp_req.pop_front();
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL store_req: got no request, required addr %h", e.addr); end
    else if ({lsb2mem_wr, lsb2mem_addr, lsb2mem_wdata, lsb2mem_size} !== {e.wr, e.addr, e.wdata, e.size}) begin
      n_fail++; $display("FAIL store_req: got wr %b addr %h wdata %h size %0d, required %b %h %h %0d",
                         lsb2mem_wr, lsb2mem_addr, lsb2mem_wdata, lsb2mem_size, e.wr, e.addr, e.wdata, e.size);
    end
    pulse_done(32'h0);
    cycles(2);
    n_checks++;
    if (dut.count !== 4'd0 || lsb2mem_enable !== 1'b0) begin
      n_fail++; $display("FAIL store_complete: got count %0d en %b, required 0 0", dut.count, lsb2mem_enable);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 9; i++) begin
      decoder2lsb_enable = 1'b1; decoder2lsb_op = OP_LW; decoder2lsb_vj = 32'h1000;
      decoder2lsb_qj = 4'd7; decoder2lsb_qk = 4'd0; decoder2lsb_imm = 32'd0;
      decoder2lsb_dest = 4'(i + 1);
      @(negedge clk_in);
      n_checks++;
      if (lsb_full !== (i + 1 >= 8)) begin
        n_fail++; $display("FAIL full_flag: after %0d dispatches got %b, required %b",
                           i + 1, lsb_full, (i + 1 >= 8));
      end
    end
    decoder2lsb_enable = 1'b0;
    n_checks++;
    if (dut.count !== 4'd8) begin
      n_fail++; $display("FAIL full_count: got %0d, required 8", dut.count);
    end
    one_cycle_flush();
    n_checks++;
    if (dut.count !== 4'd0 || lsb_full !== 1'b0) begin
      n_fail++; $display("FAIL full_flush: got count %0d full %b, required 0 0", dut.count, lsb_full);
    end
  endtask

  task automatic test_flush_store();
    bit ok;
    bit seen;
    memreq_t e;
    exp_bcast.push_back('{4'd1, 32'h0});
    exp_req.push_back('{1'b1, 32'h300, 32'h1122_3344, 2'd2});
    dispatch(OP_SW, 32'h300, 32'h1122_3344, 4'd0, 4'd0, 32'd0, 4'd1);
    dispatch(OP_LW, 32'h400, 32'h0, 4'd0, 4'd0, 32'd0, 4'd2);
    dispatch(OP_LW, 32'h404, 32'h0, 4'd0, 4'd0, 32'd0, 4'd3);
    commit(4'd1);
    wait_req(ok);
    e = exp_req.pop_front();
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL flushst_req: got no request, required addr %h", e.addr); end
    else if ({lsb2mem_wr, lsb2mem_addr, lsb2mem_wdata, lsb2mem_size} !== {e.wr, e.addr, e.wdata, e.size}) begin
      n_fail++; $display("FAIL flushst_req: got wr %b addr %h wdata %h size %0d, required %b %h %h %0d",
                         lsb2mem_wr, lsb2mem_addr, lsb2mem_wdata, lsb2mem_size, e.wr, e.addr, e.wdata, e.size);
    end
    one_cycle_flush();
    n_checks++;
    if (dut.count !== 4'd1 || lsb2mem_enable !== 1'b1) begin
      n_fail++; $display("FAIL flushst_keep: got count %0d en %b, required 1 1", dut.count, lsb2mem_enable);
    end
    pulse_done(32'h0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk_in);
      if (lsb2mem_enable) seen = 1'b1;
    end
    n_checks++;
    if (seen || dut.count !== 4'd0 || dut.state !== ST_IDLE) begin
      n_fail++; $display("FAIL flushst_after: got req %b count %0d state %0d, required 0 0 0",
                         seen, dut.count, dut.state);
    end
  endtask

  task automatic test_flush_load();
    bit ok;
    memreq_t e;
    exp_req.push_back('{1'b0, 32'h42, 32'h0, 2'd1});
    dispatch(OP_LHU, 32'h40, 32'h0, 4'd0, 4'd0, 32'd2, 4'd4);
    wait_req(ok);
    e = exp_req.pop_front();
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL flushld_req: got no request, required addr %h", e.addr); end
    else if ({lsb2mem_wr, lsb2mem_addr, lsb2mem_size} !== {e.wr, e.addr, e.size}) begin
      n_fail++; $display("FAIL flushld_req: got wr %b addr %h size %0d, required %b %h %0d",
                         lsb2mem_wr, lsb2mem_addr, lsb2mem_size, e.wr, e.addr, e.size);
    end
    one_cycle_flush();
    n_checks++;
    if (dut.state !== ST_DISCARD) begin
      n_fail++; $display("FAIL flushld_discard: got state %0d, required %0d", dut.state, ST_DISCARD);
    end
    pulse_done(32'h0000_FFFF);
    cycles(3);
    n_checks++;
    if (dut.state !== ST_IDLE || dut.count !== 4'd0 || lsb2mem_enable !== 1'b0) begin
      n_fail++; $display("FAIL flushld_after: got state %0d count %0d en %b, required 0 0 0",
                         dut.state, dut.count, lsb2mem_enable);
    end
  endtask

  task automatic test_rdy_stall();
    bit ok;
    memreq_t e;
    exp_req.push_back('{1'b0, 32'h11, 32'h0, 2'd0});
    exp_bcast.push_back('{4'd5, 32'h0000_00AB});
    dispatch(OP_LBU, 32'h10, 32'h0, 4'd0, 4'd0, 32'd1, 4'd5);
    wait_req(ok);
    e = exp_req.pop_front();
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rdy_req: got no request, required addr %h", e.addr); end
    else if ({lsb2mem_wr, lsb2mem_addr, lsb2mem_size} !== {e.wr, e.addr, e.size}) begin
      n_fail++; $display("FAIL rdy_req: got wr %b addr %h size %0d, required %b %h %0d",
                         lsb2mem_wr, lsb2mem_addr, lsb2mem_size, e.wr, e.addr, e.size);
    end
    rdy_in = 1'b0; mem2lsb_done = 1'b1; mem2lsb_rdata = 32'h1234_56AB;
    repeat (3) begin
      @(negedge clk_in);
      n_checks++;
      if (lsb2mem_enable !== 1'b1 || dut.state !== ST_MEM_WAIT || dut.count !== 4'd1 ||
          lsu2rs_bypass_enable !== 1'b0) begin
        n_fail++; $display("FAIL rdy_frozen: got en %b state %0d count %0d bcast %b, required 1 1 1 0",
                           lsb2mem_enable, dut.state, dut.count, lsu2rs_bypass_enable);
      end
    end
    rdy_in = 1'b1;
    @(negedge clk_in);
    mem2lsb_done = 1'b0;
    cycles(1);
    n_checks++;
    if (lsb2mem_enable !== 1'b0 || exp_bcast.size() != 0 || dut.count !== 4'd0) begin
      n_fail++; $display("FAIL rdy_resume: got en %b pending bcast %0d count %0d, required 0 0 0",
                         lsb2mem_enable, exp_bcast.size(), dut.count);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    memreq_t e;
    logic [31:0] rdata [2];
    rdata[0] = 32'h0000_8001;
    rdata[1] = 32'hCAFE_F00D;
    exp_req.push_back('{1'b0, 32'h7E, 32'h0, 2'd1});
    exp_bcast.push_back('{4'd7, 32'hFFFF_8001});
    exp_req.push_back('{1'b0, 32'h4, 32'h0, 2'd2});
    exp_bcast.push_back('{4'd8, 32'hCAFE_F00D});
    dispatch(OP_LH, 32'h80, 32'h0, 4'd0, 4'd0, 32'hFFFF_FFFE, 4'd7);
    dispatch(OP_LW, 32'hFFFF_FFFC, 32'h0, 4'd0, 4'd0, 32'd8, 4'd8);
    for (int k = 0; k < 2; k++) begin
      wait_req(ok);
      e = exp_req.pop_front();
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL b2b_req%0d: got no request, required addr %h", k, e.addr); end
      else if ({lsb2mem_wr, lsb2mem_addr, lsb2mem_size} !== {e.wr, e.addr, e.size}) begin
        n_fail++; $display("FAIL b2b_req%0d: got wr %b addr %h size %0d, required %b %h %0d",
                           k, lsb2mem_wr, lsb2mem_addr, lsb2mem_size, e.wr, e.addr, e.size);
      end
      pulse_done(rdata[k]);
    end
    cycles(2);
    n_checks++;
    if (exp_bcast.size() != 0 || dut.count !== 4'd0) begin
      n_fail++; $display("FAIL b2b_done: got pending bcast %0d count %0d, required 0 0",
                         exp_bcast.size(), dut.count);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    dispatch(OP_LW, 32'h500, 32'h0, 4'd0, 4'd0, 32'd0, 4'd9);
    wait_req(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rstmid_req: got no request, required one"); end
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    n_checks++;
    if (lsb2mem_enable !== 1'b0 || dut.count !== 4'd0 || dut.state !== ST_IDLE) begin
      n_fail++; $display("FAIL rstmid_state: got en %b count %0d state %0d, required 0 0 0",
                         lsb2mem_enable, dut.count, dut.state);
    end
    cycles(4);
  endtask

  initial begin : main
    test_reset();
    test_load();
    test_store_commit();
    test_full();
    test_flush_store();
    test_flush_load();
    test_rdy_stall();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (exp_bcast.size() != 0) begin
      n_fail++; $display("FAIL bcast_leftover: got %0d pending, required 0", exp_bcast.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
